// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: valid/ready stream front/back end for the 30-entry, 7-bit bubble sorter.
// Ports: In_* upstream keys, Out_* ascending keys downstream, width/Start/Ain/Ack/Aout/Done to the sorter.
module sort_stream_ctrl #(
    parameter int N = 30,
    parameter int W = 7
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [W-1:0]   In_data,
    input  logic           In_valid,
    input  logic           In_last,
    output logic           In_ready,
    output logic [W-1:0]   Out_data,
    output logic           Out_valid,
    output logic           Out_last,
    input  logic           Out_ready,
    output logic [4:0]     width,
    output logic           Start,
    output logic [N*W-1:0] Ain,
    output logic           Ack,
    input  logic [N*W-1:0] Aout,
    input  logic           Done
);

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     count_q, count_d;
    logic [4:0]     rd_idx_q, rd_idx_d;
    logic [4:0]     width_q, width_d;
    logic [N*W-1:0] ain_q, ain_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           start_q, start_d;
    logic           ack_q, ack_d;
    logic           wait_seen_q, wait_seen_d;

    logic           in_acc;
    logic           out_acc;
    logic [4:0]     rd_nxt;
    logic [4:0]     rd_sel;
    logic [W-1:0]   sel_word;

    // Next word to present: slot 0 on DRAIN entry, otherwise the slot after rd_idx.
    always_comb begin
        rd_nxt   = rd_idx_q + 5'd1;
        rd_sel   = (state_q == ST_WAIT) ? 5'd0 : rd_nxt;
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            if (5'(i) == rd_sel) sel_word = Aout[i*W +: W];
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_idx_d    = rd_idx_q;
        width_d     = width_q;
        ain_d       = ain_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        start_d     = 1'b0;
        ack_d       = 1'b0;
        wait_seen_d = wait_seen_q;

        in_acc  = (state_q == ST_LOAD) && in_ready_q && In_valid;
        out_acc = (state_q == ST_DRAIN) && out_valid_q && Out_ready;

        unique case (state_q)
            ST_LOAD: begin
                in_ready_d = 1'b1;
                if (in_acc) begin
                    for (int i = 0; i < N; i++) begin
                        if (5'(i) == count_q) ain_d[i*W +: W] = In_data;
                    end
                    count_d = count_q + 5'd1;
                    // The Nth key closes the frame whatever In_last says.
                    if (In_last || (count_q == 5'(N - 1))) begin
                        width_d    = count_q + 5'd1;
                        in_ready_d = 1'b0;
                        start_d    = 1'b1;
                        state_d    = ST_START;
                    end
                end
            end
            ST_START: begin
                wait_seen_d = 1'b0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // Done is stale on the first WAIT cycle; the sorter clears it on the Start edge.
                wait_seen_d = 1'b1;
                if (wait_seen_q && Done) begin
                    wait_seen_d = 1'b0;
                    rd_idx_d    = 5'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = sel_word;
                    out_last_d  = (width_q == 5'd1);
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_acc) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        ack_d       = 1'b1;
                        state_d     = ST_ACK;
                    end else begin
                        rd_idx_d   = rd_nxt;
                        out_data_d = sel_word;
                        out_last_d = (rd_nxt == width_q - 5'd1);
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!Done) begin
                    count_d = 5'd0;
                    ain_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                count_d     = 5'd0;
                ain_d       = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                in_ready_d  = 1'b0;
                state_d     = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_LOAD;
            count_q     <= 5'd0;
            rd_idx_q    <= 5'd0;
            width_q     <= 5'd0;
            ain_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            start_q     <= 1'b0;
            ack_q       <= 1'b0;
            wait_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_idx_q    <= rd_idx_d;
            width_q     <= width_d;
            ain_q       <= ain_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            start_q     <= start_d;
            ack_q       <= ack_d;
            wait_seen_q <= wait_seen_d;
        end
    end

    assign In_ready  = in_ready_q;
    assign Out_data  = out_data_q;
    assign Out_valid = out_valid_q;
    assign Out_last  = out_last_q;
    assign width     = width_q;
    assign Start     = start_q;
    assign Ain       = ain_q;
    assign Ack       = ack_q;

endmodule

// File: doc/sort_stream_ctrl.md
Name: sort_stream_ctrl

Overview:
- Streaming front/back end for the 30-entry, 7-bit bubble sorter.
- Accepts 1..30 unsigned keys as a valid/ready stream and packs them into the sorter's parallel input. Drives the sorter's width/Start/Ack handshake.
- Streams the sorted result back out, ascending, with the same valid/ready protocol. Sits directly upstream and downstream of the sorter core.

Parameters:
N, 30, max keys per frame; sorter array depth.
W, 7, key width in bits.

Ports:
Clk  input  1  clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
In_data  input  W  key from upstream.
In_valid  input  1  In_data valid.
In_last  input  1  marks final key of a frame; qualified by In_valid.
In_ready  output  1  controller can accept a key this cycle.
Out_data  output  W  sorted key to downstream.
Out_valid  output  1  Out_data valid.
Out_last  output  1  final sorted key of the frame.
Out_ready  input  1  downstream accepts Out_data.
width  output  5  key count for the sorter, 1..30.
Start  output  1  one-cycle start pulse to the sorter.
Ain  output  N*W  packed keys to the sorter; key i at bits [i*W +: W].
Ack  output  1  one-cycle acknowledge to the sorter.
Aout  input  N*W  sorted array from the sorter; same packing as Ain.
Done  input  1  sorter done flag.

Behaviour:
- Reset is asynchronous and active-high; the clock is Clk.
- Reset values: state=LOAD, In_ready=1, Out_valid=0, Out_last=0, Out_data=0, Start=0, Ack=0, width=0, Ain=0, count=0, rd_idx=0. Reset mid-frame discards all partial data.
- A handshake occurs on a cycle where valid and ready are both 1 at the rising edge. All outputs are registered or decoded from registered state; there is no combinational path from In_* or Out_ready to any output.
- States: LOAD, START, WAIT, DRAIN, ACK, RELEASE.
- LOAD:
  - In_ready=1.
  - On each accepted key, write it into Ain slot count and increment count.
  - Frame end is the accepted key with In_last=1, or the Nth accepted key (forced end; In_last ignored).
  - At frame end: width <= count+1, In_ready drops, next state is START.
  - Slots at or above width hold 0.
- START: Start=1 for exactly one cycle. Next state is WAIT. The sorter is guaranteed to be idle here.
- WAIT:
  - Start=0 and Done is monitored.
  - Done is not trusted on the first WAIT cycle, because the sorter clears Done on the Start edge.
  - From the second WAIT cycle on, Done=1 moves the block to DRAIN with rd_idx=0.
  - width=1 completes normally; the sorter goes straight to done.
- DRAIN:
  - Out_valid=1, Out_data=Aout[rd_idx*W +: W], Out_last=(rd_idx==width-1).
  - Aout is stable while the sorter holds done.
  - On each accepted beat, rd_idx increments. The beat with Out_last moves to ACK.
  - Out_data/Out_last stay stable while Out_valid=1 and Out_ready=0.
- ACK: Ack=1 for exactly one cycle, Out_valid=0. Next state is RELEASE.
- RELEASE:
  - Wait until Done==0, which confirms the sorter has returned to idle.
  - Then clear count and Ain, and go to LOAD.
  - In_ready is asserted the cycle after LOAD is entered.
- Latency: Start is high on the cycle after the last key is accepted. The first Out_valid is the cycle after Done is sampled high in WAIT.
- Width rules: count is 5 bits and never exceeds N. rd_idx is 5 bits and never exceeds width-1. No wrap-around is possible.
- Simultaneous events:
  - In_valid is ignored outside LOAD; In_ready=0 there.
  - Out_ready is ignored outside DRAIN.
  - Done rising during START is ignored.
- X handling: Done is undefined after reset until the sorter first runs. The controller samples Done only in WAIT (after the first cycle) and in RELEASE, where it is defined.
- Any undefined state encoding recovers to LOAD on the next clock.

Test Plan:
- Stream 5,3,9,1 with In_last on 1, Out_ready held 1 -> width=4, one Start pulse; output 1,3,5,9 with Out_last on 9; one Ack pulse; In_ready returns after Done falls.
- Single key 42 with In_last -> width=1; output 42 with Out_last=1; Ack pulse; frame completes.
- 30 keys, descending 29..0, In_last never asserted -> forced end at 30th key, width=30; output 0..29 ascending, Out_last on 29; In_ready low from the 31st cycle until RELEASE ends.
- Frame 7,7,0,127 with Out_ready toggling 1,0,0,1,... -> output 0,7,7,127 with no drops or duplicates; Out_data held while stalled.
- Two back-to-back frames (2,1 then 4,3,6) with In_valid held high -> outputs 1,2 then 3,4,6; exactly two Start and two Ack pulses; Ain upper slots zero for the second frame.
- Assert Reset mid-DRAIN after 2 of 4 beats -> all outputs at reset values immediately; the next 3-key frame sorts correctly once the sorter is also reset.
